// File: rtl/appr_mag_pkg.sv
// Shared encodings for the approximate-magnitude pipeline and its peak tracker.
package appr_mag_pkg;

  typedef enum logic [1:0] {
    MODE_HALF    = 2'd0,
    MODE_QUARTER = 2'd1,
    MODE_SHIFT78 = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } peak_state_e;

endpackage

// File: rtl/appr_mag_core.sv
// 3-stage alpha-max-plus-beta-min magnitude pipeline (register, abs, combine).
// Define APPR_MAG_ROUND_EN to round the min/max shifts half-up instead of truncating.
module appr_mag_core
  import appr_mag_pkg::*;
#(
  parameter int IW = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [1:0]           mode,
  input  logic                 frame_start,
  input  logic signed [IW-1:0] real_in,
  input  logic signed [IW-1:0] imag_in,
  output logic [IW:0]          mag,
  output logic                 val,
  output logic                 fs_out
);

  localparam logic [IW-1:0] ONE_IW = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [IW:0]   RND1   = {{IW{1'b0}}, 1'b1};
  localparam logic [IW:0]   RND2   = {{(IW-1){1'b0}}, 2'b10};
  localparam logic [IW:0]   RND4   = {{(IW-2){1'b0}}, 3'b100};

  logic [IW-1:0] re_q, re_d, im_q, im_d;
  mode_e         mode1_q, mode1_d, mode2_q, mode2_d;
  logic          fs1_q, fs1_d, fs2_q, fs2_d, fs3_q, fs3_d;
  logic          v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [IW-1:0] abr_q, abr_d, abi_q, abi_d;
  logic [IW:0]   mag_q, mag_d;
  logic [IW:0]   mx_s, mn_s, mn_h_s, mn_q_s, mx_e_s, alt_s;

  // Stage 1 capture and stage 2 absolute values; data holds when not valid.
  always_comb begin
    v1_d    = ena;
    re_d    = re_q;
    im_d    = im_q;
    mode1_d = mode1_q;
    fs1_d   = fs1_q;
    if (ena) begin
      re_d    = real_in;
      im_d    = imag_in;
      mode1_d = mode_e'(mode);
      fs1_d   = frame_start;
    end else begin
      fs1_d   = fs1_q;
    end
    v2_d    = v1_q;
    abr_d   = abr_q;
    abi_d   = abi_q;
    mode2_d = mode2_q;
    fs2_d   = fs2_q;
    if (v1_q) begin
      // Negating -2^(IW-1) in IW bits yields the unsigned value 2^(IW-1).
      abr_d   = re_q[IW-1] ? (~re_q + ONE_IW) : re_q;
      abi_d   = im_q[IW-1] ? (~im_q + ONE_IW) : im_q;
      mode2_d = mode1_q;
      fs2_d   = fs1_q;
    end else begin
      fs2_d   = fs2_q;
    end
  end

  // Stage 3 max/min and approximation select.
  always_comb begin
    if (abr_q >= abi_q) begin
      mx_s = {1'b0, abr_q};
      mn_s = {1'b0, abi_q};
    end else begin
      mx_s = {1'b0, abi_q};
      mn_s = {1'b0, abr_q};
    end
`ifdef APPR_MAG_ROUND_EN
    mn_h_s = (mn_s + RND1) >> 1;
    mn_q_s = (mn_s + RND2) >> 2;
    mx_e_s = (mx_s + RND4) >> 3;
`else
    mn_h_s = mn_s >> 1;
    mn_q_s = mn_s >> 2;
    mx_e_s = mx_s >> 3;
`endif
    alt_s = mx_s - mx_e_s + mn_h_s;
    v3_d  = v2_q;
    mag_d = mag_q;
    fs3_d = fs3_q;
    if (v2_q) begin
      fs3_d = fs2_q;
      case (mode2_q)
        MODE_QUARTER: mag_d = mx_s + mn_q_s;
        MODE_SHIFT78: mag_d = (alt_s > mx_s) ? alt_s : mx_s;
        default:      mag_d = mx_s + mn_h_s;
      endcase
    end else begin
      fs3_d = fs3_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      re_q    <= '0;
      im_q    <= '0;
      mode1_q <= MODE_HALF;
      fs1_q   <= 1'b0;
      v1_q    <= 1'b0;
      abr_q   <= '0;
      abi_q   <= '0;
      mode2_q <= MODE_HALF;
      fs2_q   <= 1'b0;
      v2_q    <= 1'b0;
      mag_q   <= '0;
      fs3_q   <= 1'b0;
      v3_q    <= 1'b0;
    end else begin
      re_q    <= re_d;
      im_q    <= im_d;
      mode1_q <= mode1_d;
      fs1_q   <= fs1_d;
      v1_q    <= v1_d;
      abr_q   <= abr_d;
      abi_q   <= abi_d;
      mode2_q <= mode2_d;
      fs2_q   <= fs2_d;
      v2_q    <= v2_d;
      mag_q   <= mag_d;
      fs3_q   <= fs3_d;
      v3_q    <= v3_d;
    end
  end

  assign mag    = mag_q;
  assign val    = v3_q;
  assign fs_out = fs3_q;

endmodule

// File: rtl/appr_mag_peak.sv
// Approximate magnitude with per-frame peak tracking on the stage-3 results.
// Optional macro APPR_MAG_ROUND_EN selects half-up rounding inside appr_mag_core.
module appr_mag_peak
  import appr_mag_pkg::*;
#(
  parameter int IW        = 22,
  parameter int FRAME_LEN = 256,
  parameter int IDXW      = $clog2(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [1:0]           mode,
  input  logic                 frame_start,
  input  logic signed [IW-1:0] real_in,
  input  logic signed [IW-1:0] imag_in,
  output logic [IW:0]          mag,
  output logic                 val,
  output logic [IW:0]          peak_mag,
  output logic [IDXW-1:0]      peak_idx,
  output logic                 peak_val
);

  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(FRAME_LEN - 1);

  logic [IW:0]     mag_s;
  logic            val_s, fs_s;
  peak_state_e     state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d, bidx_q, bidx_d, pidx_q, pidx_d;
  logic [IW:0]     best_q, best_d, pmag_q, pmag_d;
  logic            pval_q, pval_d;

  appr_mag_core #(.IW(IW)) u_core (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .mode        (mode),
    .frame_start (frame_start),
    .real_in     (real_in),
    .imag_in     (imag_in),
    .mag         (mag_s),
    .val         (val_s),
    .fs_out      (fs_s)
  );

  // Peak FSM: next state, running best and report registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    best_d  = best_q;
    bidx_d  = bidx_q;
    pmag_d  = pmag_q;
    pidx_d  = pidx_q;
    pval_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (val_s && fs_s) begin
          state_d = TRACK;
          cnt_d   = '0;
          best_d  = mag_s;
          bidx_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      TRACK: begin
        if (val_s && fs_s) begin
          cnt_d  = '0;
          best_d = mag_s;
          bidx_d = '0;
        end else if (val_s) begin
          cnt_d = cnt_q + IDX_ONE;
          // Strict compare keeps the earliest index on ties.
          if (mag_s > best_q) begin
            best_d = mag_s;
            bidx_d = cnt_d;
          end else begin
            best_d = best_q;
          end
          if (cnt_d == IDX_LAST) begin
            pmag_d  = best_d;
            pidx_d  = bidx_d;
            pval_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = TRACK;
          end
        end else begin
          state_d = TRACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Peak FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      best_q  <= '0;
      bidx_q  <= '0;
      pmag_q  <= '0;
      pidx_q  <= '0;
      pval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      best_q  <= best_d;
      bidx_q  <= bidx_d;
      pmag_q  <= pmag_d;
      pidx_q  <= pidx_d;
      pval_q  <= pval_d;
    end
  end

  assign mag      = mag_s;
  assign val      = val_s;
  assign peak_mag = pmag_q;
  assign peak_idx = pidx_q;
  assign peak_val = pval_q;

endmodule

// File: tb/tb_appr_mag_peak.sv
// Directed bench for appr_mag_peak: vector table for magnitude modes, sequences for the peak tracker.
module tb_appr_mag_peak;

  localparam int IW = 22;
  localparam int FL = 8;
  localparam int XW = 3;

  logic                 clk = 1'b0;
  logic                 rst, ena, frame_start;
  logic [1:0]           mode;
  logic signed [IW-1:0] real_in, imag_in;
  logic [IW:0]          mag, peak_mag;
  logic                 val, peak_val;
  logic [XW-1:0]        peak_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int val_cnt = 0, pv_cnt = 0, last_val_cyc = 0, pv_cyc = 0;

  typedef struct {
    logic [1:0]           mode;
    logic signed [IW-1:0] re;
    logic signed [IW-1:0] im;
    logic [IW:0]          exp;
  } vec_t;
  vec_t vecs[12];

  appr_mag_peak #(.IW(IW), .FRAME_LEN(FL), .IDXW(XW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .frame_start(frame_start),
    .real_in(real_in), .imag_in(imag_in), .mag(mag), .val(val),
    .peak_mag(peak_mag), .peak_idx(peak_idx), .peak_val(peak_val)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (val) begin
      val_cnt      <= val_cnt + 1;
      last_val_cyc <= cyc;
    end
    if (peak_val) begin
      pv_cnt <= pv_cnt + 1;
      pv_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ena = 1'b0; frame_start = 1'b0; mode = 2'd0; real_in = '0; imag_in = '0;
  endtask

  task automatic send(input int m, input logic fs, input int gap);
    ena = 1'b1; frame_start = fs; mode = 2'd0;
    real_in = IW'(m); imag_in = '0;
    tick();
    idle_inputs();
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int base_pv, base_val, k;
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_mag", mag, 0);
    check("reset_val", val, 0);
    check("reset_peak_mag", peak_mag, 0);
    check("reset_peak_idx", peak_idx, 0);
    check("reset_peak_val", peak_val, 0);

    vecs[0]  = '{2'd0, -22'sd300, 22'sd100, 23'd350};
    vecs[1]  = '{2'd1, -22'sd300, 22'sd100, 23'd325};
    vecs[2]  = '{2'd2, -22'sd300, 22'sd100, 23'd313};
    vecs[3]  = '{2'd2, 22'sd800, 22'sd0, 23'd800};
    vecs[4]  = '{2'd3, -22'sd300, 22'sd100, 23'd350};
    vecs[5]  = '{2'd0, -22'sd2097152, 22'sd0, 23'd2097152};
`ifdef APPR_MAG_ROUND_EN
    vecs[6]  = '{2'd0, 22'sd300, 22'sd101, 23'd351};
    vecs[7]  = '{2'd2, 22'sd100, 22'sd100, 23'd137};
`else
    vecs[6]  = '{2'd0, 22'sd300, 22'sd101, 23'd350};
    vecs[7]  = '{2'd2, 22'sd100, 22'sd100, 23'd138};
`endif
    vecs[8]  = '{2'd0, -22'sd2097152, -22'sd2097152, 23'd3145728};
    vecs[9]  = '{2'd1, -22'sd2097152, -22'sd2097152, 23'd2621440};
    vecs[10] = '{2'd2, -22'sd2097152, -22'sd2097152, 23'd2883584};
    vecs[11] = '{2'd1, 22'sd100, -22'sd300, 23'd325};

    for (int i = 0; i < 12; i++) begin
      ena = 1'b1; mode = vecs[i].mode; real_in = vecs[i].re; imag_in = vecs[i].im;
      tick();
      idle_inputs();
      check($sformatf("v%0d_lat1_val", i), val, 0);
      tick();
      check($sformatf("v%0d_lat2_val", i), val, 0);
      tick();
      check($sformatf("v%0d_val", i), val, 1);
      check($sformatf("v%0d_mag", i), mag, vecs[i].exp);
      tick();
      check($sformatf("v%0d_val_drop", i), val, 0);
    end

    // Frame with gaps and a tied maximum: first occurrence wins.
    do_reset();
    base_pv = pv_cnt;
    send(5, 1'b1, 1); send(9, 1'b0, 0); send(3, 1'b0, 2); send(9, 1'b0, 1);
    send(2, 1'b0, 0); send(1, 1'b0, 3); send(0, 1'b0, 0); send(4, 1'b0, 0);
    repeat (6) tick();
    check("f1_peak_cnt", pv_cnt - base_pv, 1);
    check("f1_peak_mag", peak_mag, 9);
    check("f1_peak_idx", peak_idx, 1);
    check("f1_peak_timing", pv_cyc, last_val_cyc + 1);
    check("f1_peak_val_low", peak_val, 0);

    // Pre-frame samples ignored, partial frame abandoned by restart.
    do_reset();
    base_pv = pv_cnt;
    send(100, 1'b0, 0); send(100, 1'b0, 1); send(100, 1'b0, 0);
    send(1, 1'b1, 0); send(2, 1'b0, 0); send(50, 1'b0, 1); send(3, 1'b0, 0); send(4, 1'b0, 0);
    send(7, 1'b1, 0); send(2, 1'b0, 1); send(7, 1'b0, 0); send(11, 1'b0, 0);
    send(3, 1'b0, 0); send(11, 1'b0, 2);
    repeat (5) tick();
    check("f2_no_early_peak", pv_cnt - base_pv, 0);
    send(0, 1'b0, 0); send(1, 1'b0, 0);
    repeat (5) tick();
    check("f2_peak_cnt", pv_cnt - base_pv, 1);
    check("f2_peak_mag", peak_mag, 11);
    check("f2_peak_idx", peak_idx, 3);
    check("f2_peak_timing", pv_cyc, last_val_cyc + 1);

    // Back-to-back frames: frame_start right after last sample, both fire.
    base_pv = pv_cnt;
    for (int i = 0; i < 16; i++) send((i < 8) ? (i == 6 ? 40 : 1) : (i == 10 ? 20 : 2), (i % 8) == 0, 0);
    repeat (5) tick();
    check("f3_peak_cnt", pv_cnt - base_pv, 2);
    check("f3_peak_mag", peak_mag, 20);
    check("f3_peak_idx", peak_idx, 2);
    repeat (4) tick();
    check("f3_peak_hold", peak_mag, 20);

    // Reset with samples in flight, then a continuous stream.
    send(7, 1'b1, 0);
    send(8, 1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base_val = val_cnt;
    check("rst_mag", mag, 0);
    check("rst_val", val, 0);
    check("rst_peak_mag", peak_mag, 0);
    check("rst_peak_idx", peak_idx, 0);
    check("rst_peak_val", peak_val, 0);
    repeat (5) tick();
    check("rst_no_val", val_cnt - base_val, 0);
    for (k = 0; k < 13; k++) begin
      if (k < 10) begin
        ena = 1'b1; mode = 2'd0; frame_start = 1'b0; real_in = IW'(k + 1); imag_in = '0;
      end else begin
        idle_inputs();
      end
      tick();
      check($sformatf("stream%0d_val", k), val, (k >= 2 && k <= 11) ? 1 : 0);
      if (k >= 2 && k <= 11) check($sformatf("stream%0d_mag", k), mag, k - 1);
    end
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
